// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and constants for the 7-segment scan driver.
//   scan_state_e : scan FSM states (idle, digit lit, inter-digit blanking gap)
//   SEG_BLANK    : all segments off, active-high
//   SEG_A..SEG_G : bit positions of each segment in the {a,b,c,d,e,f,g} vector
package seg7_scan_driver_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StOn,
      StGap
   } scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the value source and the scan driver.
//   value_in   : 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp_in      : per-digit decimal point, active-high
//   load       : capture value_in/dp_in into the pending word
//   enable     : scanning enable
//   blank_lz   : leading-zero suppression enable
//   anodes     : one-hot digit select at pin polarity
//   segments   : {a..g} at pin polarity, a = bit 6
//   dp         : decimal point at pin polarity
//   frame_done : one-cycle pulse at the end of the last digit's slot
// master = value source side, slave = driver side.
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);

   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic                    enable;
   logic                    blank_lz;
   logic [NUM_DIGITS-1:0]   anodes;
   logic [6:0]              segments;
   logic                    dp;
   logic                    frame_done;

   modport master (
      output value_in, dp_in, load, enable, blank_lz,
      input  anodes, segments, dp, frame_done
   );

   modport slave (
      input  value_in, dp_in, load, enable, blank_lz,
      output anodes, segments, dp, frame_done
   );

endinterface

// File: rtl/hex27segs.sv
// Hex nibble to 7-segment decoder, active-high.
//   hex_i  : 4-bit value 0..F
//   segs_o : {a,b,c,d,e,f,g}, a = bit 6, 1 = segment lit
module hex27segs (
   input  logic [3:0] hex_i,
   output logic [6:0] segs_o
);

   always_comb begin
      segs_o = 7'b0000000;
      unique case (hex_i)
         4'h0: segs_o = 7'b1111110;
         4'h1: segs_o = 7'b0110000;
         4'h2: segs_o = 7'b1101101;
         4'h3: segs_o = 7'b1111001;
         4'h4: segs_o = 7'b0110011;
         4'h5: segs_o = 7'b1011011;
         4'h6: segs_o = 7'b1011111;
         4'h7: segs_o = 7'b1110000;
         4'h8: segs_o = 7'b1111111;
         4'h9: segs_o = 7'b1111011;
         4'hA: segs_o = 7'b1110111;
         4'hB: segs_o = 7'b0011111;
         4'hC: segs_o = 7'b1001110;
         4'hD: segs_o = 7'b0111101;
         4'hE: segs_o = 7'b1001111;
         4'hF: segs_o = 7'b1000111;
         default: segs_o = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. Scans one digit per slot of
// SCAN_DIV cycles (ON phase followed by BLANK_CYCLES of all-anodes-off GAP),
// suppresses leading zeros and swaps in a newly loaded word only at frame
// boundaries so the display never tears.
//   clk_i   : system clock
//   reset_i : synchronous, active-high reset
//   bus     : slave side of seg7_scan_driver_if (inputs, pins, frame_done)
// All pin outputs are registered one cycle behind the scan state.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                clk_i,
   input  logic                reset_i,
   seg7_scan_driver_if.slave   bus
);

   localparam int unsigned ValW     = 4 * NUM_DIGITS;
   localparam int unsigned CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned OnCycles = SCAN_DIV - BLANK_CYCLES;
   localparam int unsigned GapCycles = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

   localparam logic [CntW-1:0] OnLast  = CntW'(OnCycles - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(GapCycles - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

   // Digit i>0 is suppressed when every nibble from the top down to i is zero.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [ValW-1:0] v,
                                                     input logic            en);
      logic [NUM_DIGITS-1:0] mask;
      logic                  upper_zero;
      mask       = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero = upper_zero & (v[4*i +: 4] == 4'h0);
         mask[i]    = en & upper_zero;
      end
      return mask;
   endfunction

   scan_state_e           state_q, state_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [ValW-1:0]       pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic [ValW-1:0]       disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic                  frame_done_q, frame_done_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]            segments_q, segments_d;
   logic                  dp_q, dp_d;

   logic                  advance;
   logic [3:0]            nib_sel;
   logic                  dp_sel;
   logic                  lz_sel;
   logic [NUM_DIGITS-1:0] lz;
   logic [6:0]            dec_segs;

   // Scan FSM next state.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      frame_done_d = 1'b0;
      advance      = 1'b0;
      pend_val_d   = bus.load ? bus.value_in : pend_val_q;
      pend_dp_d    = bus.load ? bus.dp_in : pend_dp_q;

      unique case (state_q)
         StIdle: begin
            if (bus.enable) begin
               state_d    = StOn;
               idx_d      = '0;
               cnt_d      = '0;
               disp_val_d = pend_val_q;
               disp_dp_d  = pend_dp_q;
            end
         end
         StOn: begin
            if (!bus.enable) begin
               state_d = StIdle;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == OnLast) begin
               cnt_d = '0;
               if (BLANK_CYCLES > 0) begin
                  state_d = StGap;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StGap: begin
            if (!bus.enable) begin
               state_d = StIdle;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == GapLast) begin
               cnt_d   = '0;
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // Frame wrap is the only point where the display word is replaced.
      if (advance) begin
         state_d = StOn;
         if (idx_q == IdxLast) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            disp_val_d   = pend_val_q;
            disp_dp_d    = pend_dp_q;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end
   end

   // Select the current digit's nibble, dp bit and blanking flag.
   always_comb begin
      lz      = lz_mask(disp_val_q, bus.blank_lz);
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      lz_sel  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IdxW'(i)) begin
            nib_sel = disp_val_q[4*i +: 4];
            dp_sel  = disp_dp_q[i];
            lz_sel  = lz[i];
         end
      end
   end

   hex27segs u_hex27segs (
      .hex_i  (nib_sel),
      .segs_o (dec_segs)
   );

   // Active-high pin image, then the polarity stage.
   always_comb begin
      logic [NUM_DIGITS-1:0] an_ah;
      logic [6:0]            seg_ah;
      logic                  dp_ah;
      an_ah  = '0;
      seg_ah = SEG_BLANK;
      dp_ah  = 1'b0;
      if (state_q == StOn) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            an_ah[i] = (idx_q == IdxW'(i));
         end
         seg_ah = lz_sel ? SEG_BLANK : dec_segs;
         dp_ah  = dp_sel;
      end
      anodes_d   = ACTIVE_LOW ? ~an_ah : an_ah;
      segments_d = ACTIVE_LOW ? ~seg_ah : seg_ah;
      dp_d       = ACTIVE_LOW ? ~dp_ah : dp_ah;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         cnt_q        <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         frame_done_q <= 1'b0;
         anodes_q     <= {NUM_DIGITS{ACTIVE_LOW}};
         segments_q   <= {7{ACTIVE_LOW}};
         dp_q         <= ACTIVE_LOW;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         frame_done_q <= frame_done_d;
         anodes_q     <= anodes_d;
         segments_q   <= segments_d;
         dp_q         <= dp_d;
      end
   end

   assign bus.anodes     = anodes_q;
   assign bus.segments   = segments_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios followed by
// randomized load/enable/blank_lz/reset traffic, compared every cycle against
// a timeline model (position within the frame -> digit and ON/GAP phase).
module tb_seg7_scan_driver;
   import seg7_scan_driver_pkg::*;

   localparam int unsigned ND    = 4;
   localparam int unsigned SDIV  = 8;
   localparam int unsigned BLANK = 2;
   localparam int unsigned FRAME = ND * SDIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4*ND-1:0] value = '0;
   logic [ND-1:0]   dpi   = '0;
   logic            load  = 1'b0;
   logic            en    = 1'b0;
   logic            blz   = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   bit              m_run;
   int              m_pos;
   logic [4*ND-1:0] m_pend_v, m_disp_v;
   logic [ND-1:0]   m_pend_dp, m_disp_dp;
   logic [ND-1:0]   e_an;
   logic [6:0]      e_seg;
   logic            e_dp, e_fd;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   assign bus.value_in = value;
   assign bus.dp_in    = dpi;
   assign bus.load     = load;
   assign bus.enable   = en;
   assign bus.blank_lz = blz;

   seg7_scan_driver #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SDIV),
      .BLANK_CYCLES (BLANK),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Active-high glyph built from the lit-segment letters of each hex digit.
   function automatic logic [6:0] glyph(input logic [3:0] h);
      string lits [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                           "aefg"};
      string s;
      logic [6:0] g;
      g = '0;
      s = lits[h];
      for (int k = 0; k < s.len(); k++) begin
         case (s.getc(k))
            "a": g[SEG_A] = 1'b1;
            "b": g[SEG_B] = 1'b1;
            "c": g[SEG_C] = 1'b1;
            "d": g[SEG_D] = 1'b1;
            "e": g[SEG_E] = 1'b1;
            "f": g[SEG_F] = 1'b1;
            "g": g[SEG_G] = 1'b1;
            default: ;
         endcase
      end
      return g;
   endfunction

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic model_edge();
      int d, w;
      if (rst) begin
         m_run = 0; m_pos = 0;
         m_pend_v = '0; m_pend_dp = '0; m_disp_v = '0; m_disp_dp = '0;
         e_an = '1; e_seg = '1; e_dp = 1'b1; e_fd = 1'b0;
         return;
      end
      // Outputs show what the scan looked like just before this edge.
      e_an = '1; e_seg = '1; e_dp = 1'b1;
      if (m_run) begin
         d = m_pos / SDIV;
         w = m_pos % SDIV;
         if (w < SDIV - BLANK) begin
            e_an[d] = 1'b0;
            e_dp    = ~m_disp_dp[d];
            if (blz && d > 0 && (m_disp_v >> (4 * d)) == 0) e_seg = '1;
            else e_seg = ~glyph(4'((m_disp_v >> (4 * d)) & 16'hF));
         end
      end
      e_fd = m_run && en && (m_pos == FRAME - 1);
      if (!m_run) begin
         if (en) begin
            m_run = 1; m_pos = 0; m_disp_v = m_pend_v; m_disp_dp = m_pend_dp;
         end
      end else if (!en) begin
         m_run = 0; m_pos = 0;
      end else begin
         m_pos++;
         if (m_pos == FRAME) begin
            m_pos = 0; m_disp_v = m_pend_v; m_disp_dp = m_pend_dp;
         end
      end
      if (load) begin
         m_pend_v = value; m_pend_dp = dpi;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("anodes", 32'(bus.anodes), 32'(e_an));
      check_eq("segments", 32'(bus.segments), 32'(e_seg));
      check_eq("dp", 32'(bus.dp), 32'(e_dp));
      check_eq("frame_done", 32'(bus.frame_done), 32'(e_fd));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   function automatic logic [4*ND-1:0] rand_word();
      logic [4*ND-1:0] v;
      v = '0;
      for (int i = 0; i < ND; i++) begin
         if ($urandom_range(1) == 1) v[4*i +: 4] = 4'($urandom_range(15));
      end
      return v;
   endfunction

   initial begin
      // Reset held 3 cycles, then idle with enable low.
      rst = 1'b1;
      run(3);
      check_eq("reset_anodes", 32'(bus.anodes), 32'h0000_000F);
      check_eq("reset_segments", 32'(bus.segments), 32'h0000_007F);
      check_eq("reset_dp", 32'(bus.dp), 32'h1);
      rst = 1'b0;
      run(5);

      // Load 12AF, then enable: first lit digit is 'F' on digit 0.
      load = 1'b1; value = 16'h12AF; dpi = 4'b0000;
      cycle();
      load = 1'b0; en = 1'b1;
      run(2);
      check_eq("first_anodes", 32'(bus.anodes), 32'h0000_000E);
      check_eq("first_segments", 32'(bus.segments), 32'h0000_0038);
      run(3 * FRAME);

      // Leading-zero suppression.
      blz = 1'b1;
      load = 1'b1; value = 16'h0000; cycle(); load = 1'b0;
      run(2 * FRAME);
      load = 1'b1; value = 16'h0050; dpi = 4'b0100; cycle(); load = 1'b0;
      run(2 * FRAME);
      blz = 1'b0;

      // Mid-frame load must not tear the frame in progress.
      load = 1'b1; value = 16'hFFFF; dpi = 4'b1010; cycle(); load = 1'b0;
      run(2 * FRAME);
      while (m_pos != 2 * SDIV + 1) cycle();
      load = 1'b1; value = 16'h1234; cycle(); load = 1'b0;
      run(2 * FRAME);

      // Enable dropped during digit 1 ON, then re-enabled.
      while (m_pos != SDIV + 2) cycle();
      en = 1'b0; run(6);
      en = 1'b1; run(FRAME + 4);

      // Reset pulsed during digit 3 GAP.
      while (m_pos != 3 * SDIV + SDIV - 1) cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      run(2 * FRAME);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(399) == 0);
         load  = ($urandom_range(15) == 0);
         value = rand_word();
         dpi   = 4'($urandom_range(15));
         if (en) begin
            if ($urandom_range(99) == 0) en = 1'b0;
         end else if ($urandom_range(3) == 0) begin
            en = 1'b1;
         end
         if ($urandom_range(199) == 0) blz = ~blz;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Holds a display word and scans one digit at a time: nibble select -> hex27segs decode -> registered segment/anode/dp outputs.
- Inserts an inter-digit blanking gap against ghosting, suppresses leading zeros, and updates the word only at frame boundaries so the display never tears.
- Sits between the system value source and the board display pins; it is the direct upstream feeder of hex27segs.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clk cycles per digit slot (ON + GAP); must exceed BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles per slot with all anodes off; 0 means no GAP phase.
- ACTIVE_LOW, 1, 1 means anodes, segments and dp are driven active-low at the pins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value_in  in  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0], least significant
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high
- load  in  1  capture value_in/dp_in into the pending register
- enable  in  1  scanning enable
- blank_lz  in  1  leading-zero suppression enable
- anodes  out  NUM_DIGITS  one-hot digit select, pin polarity per ACTIVE_LOW
- segments  out  7  {a,b,c,d,e,f,g}, a = bit 6, pin polarity per ACTIVE_LOW
- dp  out  1  decimal point, pin polarity per ACTIVE_LOW
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Reset:
  - state IDLE; digit index, slot counter, pending, display and dp registers all 0.
  - anodes, segments and dp outputs inactive (all 1s when ACTIVE_LOW=1).
  - frame_done = 0.
  - Reset asserted mid-frame takes effect on the next edge; no partial-frame completion.
- Load:
  - load=1 writes value_in/dp_in to the pending register at the edge.
  - The display register copies the pending register only on entry to ON with index 0.
  - A load in that same cycle lands in pending and is displayed in the following frame.
- FSM states: IDLE, ON, GAP.
  - IDLE: if enable=1, go to ON next edge with index=0, counter=0, display <= pending.
  - ON: counter counts 0..SCAN_DIV-BLANK_CYCLES-1. At terminal count, go to GAP if BLANK_CYCLES>0; otherwise advance directly to the next ON slot.
  - GAP: counter counts BLANK_CYCLES cycles, then advances to the next slot.
  - Advance: index+1. If index = NUM_DIGITS-1, wrap to 0, assert frame_done for one cycle, and copy display <= pending.
  - enable=0 in ON or GAP: go to IDLE next edge and reset index to 0. enable is ignored only in the cycle reset is high.
- Output timing:
  - All outputs are registered and reflect the state/index one clock after the state register; fixed latency = 1.
  - frame_done is registered with the same 1-cycle lag.
- Outputs per state:
  - IDLE and GAP: anodes, segments and dp inactive.
  - ON: anode[index] active, all others inactive; segments = decode(display nibble[index]); dp = display_dp[index].
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and nibbles N-1..i are all 0.
  - Blanked digit: segments inactive; anode still driven; dp still shown.
  - Digit 0 is never blanked.
- Counter width: $clog2(SCAN_DIV). Index width: $clog2(NUM_DIGITS), minimum 1.
- Polarity: when ACTIVE_LOW=1, the final stage inverts the active-high decoder output, anodes and dp.

Decomposition:
- Shared package holds:
  - scan state enum {IDLE, ON, GAP};
  - SEG_BLANK constant 7'b0000000 (active-high);
  - segment-index constants A..G = 6..0.
- One sub-module: the existing hex27segs, instantiated once, driven by the muxed display nibble.
- Leading-zero mask is a combinational function of the display register, in the same file.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
- Reset held 3 cycles -> anodes=4'b1111, segments=7'b1111111, dp=1, frame_done=0; all hold while enable=0.
- load 16'h12AF, dp_in=4'b0000, enable=1 -> anodes=4'b1110 with segments=7'b0111000 ('F') for 6 cycles; then 4'b1111 for 2 cycles; then 4'b1101 with segments=7'b0001000 ('A'); frame_done pulses once every 32 cycles.
- load 16'h0000, blank_lz=1 -> digits 3..1 show segments=7'b1111111; digit 0 shows 7'b0000001 ('0'). Repeat with 16'h0050 -> digits 3 and 2 blank, digit 1 shows '5' = 7'b0100100.
- load 16'h1234 while digit 2 is ON, with previous word 16'hFFFF -> digits 2 and 3 still show 'F'; '1234' appears starting at the slot after frame_done.
- enable dropped during digit 1 ON -> outputs inactive from 2 edges later; re-enable -> digit 0 is the first digit lit.
- reset pulsed during digit 3 GAP -> next frame starts at digit 0 showing 0 (pending cleared); no frame_done pulse is produced for the aborted frame.
